// File: rtl/cdb_wb_arbiter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : cdb_wb_arbiter_pkg
// Brief   : Shared constants and the round-robin helper for the CDB arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package cdb_wb_arbiter_pkg;

    localparam int ROB_WIDTH_BIT  = 5;
    localparam int CDB_SRC_NUM    = 3;
    localparam int CDB_SRC_ALU    = 0;
    localparam int CDB_SRC_LSB    = 1;
    localparam int CDB_SRC_BR     = 2;
    localparam int CDB_FIFO_DEPTH = 4;

    typedef logic [1:0] src_idx_t;

    // Next source in round-robin order; index 3 is never produced.
    function automatic src_idx_t rr_next(input src_idx_t s);
        case (s)
            src_idx_t'(CDB_SRC_ALU): rr_next = src_idx_t'(CDB_SRC_LSB);
            src_idx_t'(CDB_SRC_LSB): rr_next = src_idx_t'(CDB_SRC_BR);
            default:                 rr_next = src_idx_t'(CDB_SRC_ALU);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_wb_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : cdb_wb_arbiter_if
// Brief   : Source push channels and the registered CDB broadcast.
// Revision: 1.0 - initial release
// ============================================================================
interface cdb_wb_arbiter_if
    import cdb_wb_arbiter_pkg::*;
#(
    parameter int ROB_W = ROB_WIDTH_BIT
) ();

    logic [CDB_SRC_NUM-1:0]       src_valid_in;
    logic [CDB_SRC_NUM*ROB_W-1:0] src_id_in;
    logic [CDB_SRC_NUM*32-1:0]    src_val_in;
    logic [CDB_SRC_NUM-1:0]       src_ready_out;
    logic                         cdb_valid_out;
    logic [ROB_W-1:0]             cdb_id_out;
    logic [31:0]                  cdb_val_out;
    src_idx_t                     cdb_src_out;

    modport master (
        output src_valid_in, src_id_in, src_val_in,
        input  src_ready_out, cdb_valid_out, cdb_id_out, cdb_val_out, cdb_src_out
    );

    modport slave (
        input  src_valid_in, src_id_in, src_val_in,
        output src_ready_out, cdb_valid_out, cdb_id_out, cdb_val_out, cdb_src_out
    );

endinterface
`default_nettype wire

// File: rtl/cdb_wb_arbiter_wb_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : wb_fifo
// Brief   : Small per-source result FIFO with wrap-bit pointers and flush.
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  wire logic             clk_in,
    input  wire logic             rst_n_in,
    input  wire logic             push_in,
    input  wire logic             pop_in,
    input  wire logic             flush_in,
    input  wire logic [WIDTH-1:0] data_in,
    output logic                  full_out,
    output logic                  empty_out,
    output logic      [WIDTH-1:0] head_out
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_out = (wr_ptr_q == rd_ptr_q);
    assign full_out  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_out  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_in) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_in)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: it is only read when the pointers say it is valid.
    always_ff @(posedge clk_in) begin
        if (push_in && !flush_in) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end

endmodule
`default_nettype wire

// File: rtl/cdb_wb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : cdb_wb_arbiter
// Brief   : Round-robin drain of three completion FIFOs onto a registered CDB.
//           Optional same-cycle FIFO bypass enabled by macro CDB_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module cdb_wb_arbiter
    import cdb_wb_arbiter_pkg::*;
#(
    parameter int ROB_W      = ROB_WIDTH_BIT,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  wire logic clk_in,
    input  wire logic rst_n_in,
    input  wire logic rdy_in,
    input  wire logic clear_in,
    cdb_wb_arbiter_if.slave bus
);

    localparam int EW = ROB_W + 32;

    logic [CDB_SRC_NUM-1:0] ready;
    logic [CDB_SRC_NUM-1:0] push;
    logic [CDB_SRC_NUM-1:0] fifo_push;
    logic [CDB_SRC_NUM-1:0] fifo_pop;
    logic [CDB_SRC_NUM-1:0] full;
    logic [CDB_SRC_NUM-1:0] empty;
    logic [EW-1:0]          head [CDB_SRC_NUM];

    logic       fifo_grant;
    src_idx_t   fifo_idx;
    src_idx_t   cand;
    logic       bypass;
    logic       pop_en;
    logic       flush;

    src_idx_t   rr_q,        rr_d;
    logic       cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0] cdb_id_q, cdb_id_d;
    logic [31:0] cdb_val_q,  cdb_val_d;
    src_idx_t   cdb_src_q,   cdb_src_d;

    assign flush  = clear_in && rdy_in;
    assign pop_en = fifo_grant && !bypass && rdy_in && !clear_in;

    generate
        for (genvar i = 0; i < CDB_SRC_NUM; i++) begin : g_src
            assign ready[i]     = !full[i] && rdy_in && !clear_in;
            assign push[i]      = bus.src_valid_in[i] && ready[i];
            assign fifo_push[i] = push[i] && !(bypass && (rr_q == src_idx_t'(i)));
            assign fifo_pop[i]  = pop_en && (fifo_idx == src_idx_t'(i));

            wb_fifo #(
                .WIDTH (EW),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk_in    (clk_in),
                .rst_n_in  (rst_n_in),
                .push_in   (fifo_push[i]),
                .pop_in    (fifo_pop[i]),
                .flush_in  (flush),
                .data_in   ({bus.src_id_in[i*ROB_W +: ROB_W], bus.src_val_in[i*32 +: 32]}),
                .full_out  (full[i]),
                .empty_out (empty[i]),
                .head_out  (head[i])
            );
        end
    endgenerate

    assign bus.src_ready_out = ready;

    // First non-empty FIFO scanning from rr; only pre-edge contents compete.
    always_comb begin
        fifo_grant = 1'b0;
        fifo_idx   = rr_q;
        cand       = rr_q;
        for (int k = 0; k < CDB_SRC_NUM; k++) begin
            if (!fifo_grant && !empty[cand]) begin
                fifo_grant = 1'b1;
                fifo_idx   = cand;
            end
            cand = rr_next(cand);
        end
    end

`ifdef CDB_BYPASS_EN
    // The rr source is top priority, so its fresh push can skip an empty FIFO.
    assign bypass = empty[rr_q] && push[rr_q];
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        rr_d        = rr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_id_d    = cdb_id_q;
        cdb_val_d   = cdb_val_q;
        cdb_src_d   = cdb_src_q;
        if (rdy_in) begin
            if (clear_in) begin
                cdb_valid_d = 1'b0;
                rr_d        = '0;
            end else if (bypass) begin
                cdb_valid_d = 1'b1;
                cdb_id_d    = bus.src_id_in[int'(rr_q)*ROB_W +: ROB_W];
                cdb_val_d   = bus.src_val_in[int'(rr_q)*32 +: 32];
                cdb_src_d   = rr_q;
                rr_d        = rr_next(rr_q);
            end else if (fifo_grant) begin
                cdb_valid_d = 1'b1;
                {cdb_id_d, cdb_val_d} = head[fifo_idx];
                cdb_src_d   = fifo_idx;
                rr_d        = rr_next(fifo_idx);
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_id_q    <= '0;
            cdb_val_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_id_q    <= cdb_id_d;
            cdb_val_q   <= cdb_val_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.cdb_valid_out = cdb_valid_q;
    assign bus.cdb_id_out    = cdb_id_q;
    assign bus.cdb_val_out   = cdb_val_q;
    assign bus.cdb_src_out   = cdb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_wb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_cdb_wb_arbiter
// Brief   : Scoreboard bench; a queue-level model predicts each CDB cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_wb_arbiter;
    import cdb_wb_arbiter_pkg::*;

    localparam int RW    = ROB_WIDTH_BIT;
    localparam int DEPTH = CDB_FIFO_DEPTH;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in   = 1'b0;
    logic clear_in = 1'b0;

    cdb_wb_arbiter_if #(.ROB_W(RW)) bus ();

    cdb_wb_arbiter #(.ROB_W(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic           v;
        logic [1:0]     src;
        logic [RW-1:0]  id;
        logic [31:0]    val;
    } exp_t;

    exp_t          expq[$];
    exp_t          last_e;
    logic [RW+31:0] mf [3][DEPTH];
    int            cnt [3];
    int            rr_m;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3*RW-1:0] rnd_ids();
        logic [3*RW-1:0] r;
        for (int i = 0; i < 3; i++) r[i*RW +: RW] = RW'($urandom);
        return r;
    endfunction

    function automatic logic [95:0] rnd_vals();
        logic [95:0] r;
        for (int i = 0; i < 3; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock of stimulus; the model predicts the CDB after the next edge.
    task automatic cycle(input logic [2:0] v, input logic rdy, input logic clr,
                         input logic [3*RW-1:0] ids, input logic [95:0] vals);
        logic [2:0] acc;
        logic       er;
        logic       byp;
        exp_t       e;
        int         w;
        int         j;
        @(negedge clk_in);
        bus.src_valid_in = v;
        bus.src_id_in    = ids;
        bus.src_val_in   = vals;
        rdy_in           = rdy;
        clear_in         = clr;
        #1;
        for (int i = 0; i < 3; i++) begin
            er = (cnt[i] < DEPTH) && rdy && !clr;
            check($sformatf("ready[%0d]", i), 64'(bus.src_ready_out[i]), 64'(er));
            acc[i] = v[i] && er;
        end
        if (rdy) begin
            e = '{v: 1'b0, src: 2'd0, id: '0, val: '0};
            if (clr) begin
                cnt  = '{0, 0, 0};
                rr_m = 0;
            end else begin
                w   = -1;
                byp = 1'b0;
`ifdef CDB_BYPASS_EN
                if (cnt[rr_m] == 0 && acc[rr_m]) begin
                    w     = rr_m;
                    byp   = 1'b1;
                    e.v   = 1'b1;
                    e.src = 2'(w);
                    e.id  = ids[w*RW +: RW];
                    e.val = vals[w*32 +: 32];
                end
`endif
                for (int k = 0; k < 3; k++) begin
                    j = (rr_m + k) % 3;
                    if (w < 0 && cnt[j] > 0) w = j;
                end
                if (w >= 0 && !byp) begin
                    {e.id, e.val} = mf[w][0];
                    for (int s = 0; s < DEPTH - 1; s++) mf[w][s] = mf[w][s+1];
                    cnt[w]--;
                    e.v   = 1'b1;
                    e.src = 2'(w);
                end
                for (int i = 0; i < 3; i++) begin
                    if (acc[i] && !(byp && i == w)) begin
                        mf[i][cnt[i]] = {ids[i*RW +: RW], vals[i*32 +: 32]};
                        cnt[i]++;
                    end
                end
                if (w >= 0) rr_m = (w + 1) % 3;
            end
            expq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(3'b000, 1'b1, 1'b0, rnd_ids(), rnd_vals());
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, 64'(bus.cdb_valid_out), 64'd0);
        check({tag, " id"},    64'(bus.cdb_id_out),    64'd0);
        check({tag, " val"},   64'(bus.cdb_val_out),   64'd0);
        check({tag, " src"},   64'(bus.cdb_src_out),   64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        check_zero("async reset");
        cnt    = '{0, 0, 0};
        rr_m   = 0;
        last_e = '{v: 1'b0, src: 2'd0, id: '0, val: '0};
        expq.delete();
        @(negedge clk_in);
        rdy_in = 1'b0;
        bus.src_valid_in = '0;
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b1;
    endtask

    // Monitor: one expected entry per rdy-high edge; CDB must hold otherwise.
    initial begin
        logic r;
        logic rn;
        exp_t e;
        forever begin
            @(posedge clk_in);
            r  = rdy_in;
            rn = rst_n_in;
            #1;
            if (rn && rst_n_in) begin
                if (r) begin
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard: got CDB sample expected no pending entry at %0t", $time);
                    end else begin
                        e = expq.pop_front();
                        if (e.v) last_e = e;
                        else     last_e.v = 1'b0;
                    end
                end
                check("cdb_valid", 64'(bus.cdb_valid_out), 64'(last_e.v));
                check("cdb_id",    64'(bus.cdb_id_out),    64'(last_e.id));
                check("cdb_val",   64'(bus.cdb_val_out),   64'(last_e.val));
                check("cdb_src",   64'(bus.cdb_src_out),   64'(last_e.src));
            end
        end
    end

    initial begin
        logic [3*RW-1:0] ids1;
        logic [95:0]     vals1;
        bus.src_valid_in = '0;
        bus.src_id_in    = '0;
        bus.src_val_in   = '0;
        last_e = '{v: 1'b0, src: 2'd0, id: '0, val: '0};
        cnt    = '{0, 0, 0};
        rr_m   = 0;
        ids1   = rnd_ids();
        vals1  = rnd_vals();
        ids1[RW-1:0]  = RW'(5);
        vals1[31:0]   = 32'hDEADBEEF;

        #12;
        check_zero("reset");
        rst_n_in = 1'b1;

        cycle(3'b001, 1'b1, 1'b0, ids1, vals1);
        idle(4);

        for (int i = 0; i < 12; i++) cycle(3'b111, 1'b1, 1'b0, rnd_ids(), rnd_vals());
        idle(30);

        for (int i = 0; i < 8; i++) cycle(3'b111, 1'b1, 1'b0, rnd_ids(), rnd_vals());
        for (int i = 0; i < 3; i++) cycle(3'b111, 1'b0, 1'b0, rnd_ids(), rnd_vals());
        idle(20);

        for (int i = 0; i < 3; i++) cycle(3'b111, 1'b1, 1'b0, rnd_ids(), rnd_vals());
        cycle(3'b010, 1'b1, 1'b0, rnd_ids(), rnd_vals());
        cycle(3'b100, 1'b1, 1'b1, rnd_ids(), rnd_vals());
        idle(3);
        cycle(3'b111, 1'b1, 1'b0, rnd_ids(), rnd_vals());
        idle(5);

        for (int i = 0; i < 4; i++) cycle(3'b111, 1'b1, 1'b0, rnd_ids(), rnd_vals());
        do_reset();
        cycle(3'b001, 1'b1, 1'b0, ids1, vals1);
        idle(4);

        for (int i = 0; i < 800; i++)
            cycle(3'($urandom), ($urandom % 5) != 0, ($urandom % 40) == 0,
                  rnd_ids(), rnd_vals());
        idle(20);
        @(negedge clk_in);
        rdy_in = 1'b0;
        @(negedge clk_in);
        check("drained", 64'(expq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
